// File: rtl/wb_lfsr_pkg.sv
// Shared definitions for the Wishbone-controlled LFSR generator.
//   - Register map addresses (2-bit word address).
//   - CTRL register bit positions.
//   - LFSR stepping mode enum.
package wb_lfsr_pkg;

  // Register map
  localparam logic [1:0] AddrCtrl  = 2'd0;
  localparam logic [1:0] AddrTaps  = 2'd1;
  localparam logic [1:0] AddrState = 2'd2;
  localparam logic [1:0] AddrSteps = 2'd3;

  // CTRL register bit positions
  localparam int unsigned CtrlRun  = 0;  // RW: free-run enable
  localparam int unsigned CtrlMode = 1;  // RW: 0 Fibonacci, 1 Galois
  localparam int unsigned CtrlBusy = 2;  // RO: step counter non-zero
  localparam int unsigned CtrlDone = 3;  // sticky, write-1-to-clear

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } lfsr_mode_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step LFSR next-state function.
// Ports:
//   state_i  current LFSR state
//   taps_i   feedback tap mask
//   mode_i   FIBONACCI (shift left, XOR-reduce feedback into bit 0)
//            or GALOIS (shift right, XOR taps in when bit 0 falls out)
//   state_o  state after one step
//   bit_o    serial bit shifted out by this step
module lfsr_step
  import wb_lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] taps_i,
  input  lfsr_mode_e       mode_i,
  output logic [WIDTH-1:0] state_o,
  output logic             bit_o
);

  always_comb begin
    state_o = state_i;
    bit_o   = 1'b0;
    if (mode_i == GALOIS) begin
      bit_o   = state_i[0];
      state_o = (state_i >> 1) ^ (state_i[0] ? taps_i : '0);
    end else begin
      bit_o   = state_i[WIDTH-1];
      state_o = {state_i[WIDTH-2:0], ^(state_i & taps_i)};
    end
  end

endmodule

// File: rtl/wb_lfsr_gen.sv
// Wishbone (pipelined) slave wrapping a programmable LFSR.
// Registers: CTRL (RUN, MODE, BUSY, DONE), TAPS, STATE, STEPS.
// The LFSR steps every cycle while RUN=1 or the STEPS counter is non-zero.
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_wb_cyc/stb/we/addr/data Wishbone request
//   o_wb_stall/ack/data       Wishbone response (data valid with ack)
//   o_lfsr_bit                bit shifted out by the most recent step
//   o_lfsr_state              current LFSR state
module wb_lfsr_gen
  import wb_lfsr_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter logic [31:0] RESET_TAPS = 32'h0000_B400,
  parameter logic [31:0] RESET_SEED = 32'd1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [1:0]       i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [WIDTH-1:0] o_wb_data,
  output logic             o_lfsr_bit,
  output logic [WIDTH-1:0] o_lfsr_state
);

  localparam logic [WIDTH-1:0] TapsInit = RESET_TAPS[WIDTH-1:0];
  // An all-zero LFSR never leaves zero, so a zero seed is forced to 1.
  localparam logic [WIDTH-1:0] SeedInit =
      (RESET_SEED[WIDTH-1:0] == '0) ? WIDTH'(1) : RESET_SEED[WIDTH-1:0];

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             run_q, run_d;
  lfsr_mode_e       mode_q, mode_d;
  logic             done_q, done_d;
  logic             bit_q, bit_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             busy;
  logic             wb_req;
  logic             locked_wr;
  logic             accept;
  logic             wr_en;
  logic             step_en;
  logic             steps_reload;
  logic [WIDTH-1:0] step_state;
  logic             step_bit;
  logic [WIDTH-1:0] wr_state;
  logic [WIDTH-1:0] ctrl_rd;

  lfsr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .state_i(state_q),
    .taps_i (taps_q),
    .mode_i (mode_q),
    .state_o(step_state),
    .bit_o  (step_bit)
  );

  assign busy    = (steps_q != '0);
  assign wb_req  = i_wb_cyc & i_wb_stb;
  assign step_en = run_q | busy;

  // STATE/TAPS writes would disturb a counted burst, so they wait it out.
  assign locked_wr  = i_wb_we & ((i_wb_addr == AddrState) | (i_wb_addr == AddrTaps));
  assign o_wb_stall = wb_req & locked_wr & busy;
  assign accept     = wb_req & ~o_wb_stall;
  assign wr_en      = accept & i_wb_we;

  assign steps_reload = wr_en & (i_wb_addr == AddrSteps);
  assign wr_state     = (i_wb_data == '0) ? WIDTH'(1) : i_wb_data;

  always_comb begin
    ctrl_rd           = '0;
    ctrl_rd[CtrlRun]  = run_q;
    ctrl_rd[CtrlMode] = (mode_q == GALOIS);
    ctrl_rd[CtrlBusy] = busy;
    ctrl_rd[CtrlDone] = done_q;
  end

  // Register and LFSR next state
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    taps_d  = taps_q;
    steps_d = steps_q;
    run_d   = run_q;
    mode_d  = mode_q;
    done_d  = done_q;

    if (step_en) begin
      state_d = step_state;
      bit_d   = step_bit;
    end
    if (busy) begin
      steps_d = steps_q - WIDTH'(1);
    end

    if (wr_en) begin
      case (i_wb_addr)
        AddrCtrl: begin
          run_d  = i_wb_data[CtrlRun];
          mode_d = i_wb_data[CtrlMode] ? GALOIS : FIBONACCI;
          if (i_wb_data[CtrlDone]) begin
            done_d = 1'b0;
          end
        end
        AddrTaps:  taps_d = i_wb_data;
        AddrState: begin
          // A direct load replaces the step entirely; the output bit holds.
          state_d = wr_state;
          bit_d   = bit_q;
        end
        AddrSteps: steps_d = i_wb_data;
        default: ;
      endcase
    end

    // Evaluated after the W1C so expiry wins; a reload cancels the expiry.
    if (busy && (steps_q == WIDTH'(1)) && !steps_reload) begin
      done_d = 1'b1;
    end
  end

  // Bus response next state: read data is captured at acceptance.
  always_comb begin
    ack_d   = accept;
    rdata_d = '0;
    if (accept && !i_wb_we) begin
      case (i_wb_addr)
        AddrCtrl:  rdata_d = ctrl_rd;
        AddrTaps:  rdata_d = taps_q;
        AddrState: rdata_d = state_q;
        AddrSteps: rdata_d = steps_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= SeedInit;
      taps_q  <= TapsInit;
      steps_q <= '0;
      run_q   <= 1'b0;
      mode_q  <= FIBONACCI;
      done_q  <= 1'b0;
      bit_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      taps_q  <= taps_d;
      steps_q <= steps_d;
      run_q   <= run_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Dropping CYC abandons the cycle, so a pending ack must not escape.
  assign o_wb_ack     = ack_q & i_wb_cyc;
  assign o_wb_data    = rdata_q;
  assign o_lfsr_bit   = bit_q;
  assign o_lfsr_state = state_q;

endmodule

// File: tb/tb_wb_lfsr_gen.sv
module tb_wb_lfsr_gen;
  import wb_lfsr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'd0;
  logic        stall, ack, lbit;
  logic [15:0] rdata, lstate;

  logic        cyc8 = 1'b0, stb8 = 1'b0, we8 = 1'b0;
  logic [1:0]  addr8 = 2'd0;
  logic [7:0]  wdata8 = 8'd0;
  logic        stall8, ack8, lbit8;
  logic [7:0]  rdata8, lstate8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_lfsr_gen dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_wb_cyc    (cyc),
    .i_wb_stb    (stb),
    .i_wb_we     (we),
    .i_wb_addr   (addr),
    .i_wb_data   (wdata),
    .o_wb_stall  (stall),
    .o_wb_ack    (ack),
    .o_wb_data   (rdata),
    .o_lfsr_bit  (lbit),
    .o_lfsr_state(lstate)
  );

  wb_lfsr_gen #(
    .WIDTH     (8),
    .RESET_TAPS(32'h0000_000C),
    .RESET_SEED(32'd1)
  ) dut8 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_wb_cyc    (cyc8),
    .i_wb_stb    (stb8),
    .i_wb_we     (we8),
    .i_wb_addr   (addr8),
    .i_wb_data   (wdata8),
    .o_wb_stall  (stall8),
    .o_wb_ack    (ack8),
    .o_wb_data   (rdata8),
    .o_lfsr_bit  (lbit8),
    .o_lfsr_state(lstate8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: apply n steps of the LFSR rules using plain integer arithmetic.
  task automatic model_run(input bit galois, input logic [15:0] taps, input logic [15:0] seed,
                           input int n, output logic [15:0] st, output logic ob);
    int unsigned s;
    int unsigned t;
    s  = (seed == 16'd0) ? 1 : int'(seed);
    t  = int'(taps);
    ob = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (galois) begin
        ob = ((s % 2) != 0);
        s  = s / 2;
        if (ob) s = s ^ t;
      end else begin
        ob = (((s / 32768) % 2) != 0);
        s  = ((s * 2) % 65536) + ((($countones(s & t) % 2) != 0) ? 1 : 0);
      end
    end
    st = s[15:0];
  endtask

  // Called and returning at posedge+1; one request, waits out stall, checks the ack.
  task automatic xfer(input logic w, input logic [1:0] a, input logic [15:0] d,
                      output logic [15:0] q, output int stalls);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    stalls = 0;
    #1;
    while (stall && stalls < 300) begin
      @(posedge clk); #2;
      stalls++;
    end
    if (stalls >= 300) chk("stall_timeout", stall, 0);
    @(posedge clk); #1;
    chk($sformatf("ack_addr%0d", a), ack, 1);
    q   = rdata;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] q;
    int s;
    xfer(1'b1, a, d, q, s);
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] q);
    int s;
    xfer(1'b0, a, 16'd0, q, s);
  endtask

  task automatic rd_chk(input string n, input logic [1:0] a, input logic [15:0] e);
    logic [15:0] q;
    rd(a, q);
    chk(n, q, e);
  endtask

  task automatic wait_idle();
    logic [15:0] q;
    int k;
    k = 0;
    do begin
      rd(AddrCtrl, q);
      k++;
    end while (q[CtrlBusy] && k < 200);
    chk("busy_clears", q[CtrlBusy], 0);
  endtask

  // Clears DONE, sets mode (RUN=0), taps and seed.
  task automatic setup(input bit g, input logic [15:0] t, input logic [15:0] s);
    wr(AddrCtrl, g ? 16'h000A : 16'h0008);
    wr(AddrTaps, t);
    wr(AddrState, s);
  endtask

  typedef struct {
    bit          galois;
    logic [15:0] taps;
    logic [15:0] seed;
    int          n;
    logic [15:0] exp_state;
    logic        exp_bit;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  seq8[15];
  logic [15:0] exp4[4];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q, est;
    logic        eb;
    bit          g;
    logic [15:0] t, s;
    int          n, stalls, first;
    logic [7:0]  prev8;

    vecs[0] = '{1'b1, 16'hB400, 16'h0001, 1,  16'hB400, 1'b1};
    vecs[1] = '{1'b1, 16'hB400, 16'h0001, 2,  16'h5A00, 1'b0};
    vecs[2] = '{1'b0, 16'hB400, 16'h0001, 10, 16'h0400, 1'b0};
    vecs[3] = '{1'b0, 16'hB400, 16'h0001, 11, 16'h0801, 1'b0};
    vecs[4] = '{1'b1, 16'hB400, 16'h0003, 1,  16'hB401, 1'b1};
    vecs[5] = '{1'b0, 16'h8000, 16'h8000, 1,  16'h0001, 1'b1};
    seq8 = '{8'hC, 8'h6, 8'h3, 8'hD, 8'hA, 8'h5, 8'hE, 8'h7,
             8'hF, 8'hB, 8'h9, 8'h8, 8'h4, 8'h2, 8'h1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", lstate, 16'h0001);
    chk("rst_bit", lbit, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", rdata, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    rd_chk("rst_ctrl", AddrCtrl, 16'h0000);
    rd_chk("rst_taps", AddrTaps, 16'hB400);
    rd_chk("rst_steps", AddrSteps, 16'h0000);

    // Directed vectors
    foreach (vecs[i]) begin
      setup(vecs[i].galois, vecs[i].taps, vecs[i].seed);
      wr(AddrSteps, 16'(vecs[i].n));
      wait_idle();
      rd_chk($sformatf("vec%0d_state_rd", i), AddrState, vecs[i].exp_state);
      chk($sformatf("vec%0d_state_out", i), lstate, vecs[i].exp_state);
      chk($sformatf("vec%0d_bit", i), lbit, vecs[i].exp_bit);
      rd_chk($sformatf("vec%0d_ctrl", i), AddrCtrl, vecs[i].galois ? 16'h000A : 16'h0008);
    end

    // Randomized bursts against the reference model
    for (int i = 0; i < 12; i++) begin
      g = bit'($urandom_range(0, 1));
      t = 16'($urandom);
      s = 16'($urandom);
      n = int'($urandom_range(1, 20));
      setup(g, t, s);
      wr(AddrSteps, 16'(n));
      wait_idle();
      model_run(g, t, s, n, est, eb);
      rd_chk($sformatf("rnd%0d_state_rd", i), AddrState, est);
      chk($sformatf("rnd%0d_state_out", i), lstate, est);
      chk($sformatf("rnd%0d_bit", i), lbit, eb);
      rd_chk($sformatf("rnd%0d_ctrl", i), AddrCtrl, g ? 16'h000A : 16'h0008);
    end

    // Zero seed coercion; STATE write stalls for the whole burst
    setup(1'b1, 16'hB400, 16'h0001);
    wr(AddrState, 16'h0000);
    rd_chk("zero_seed", AddrState, 16'h0001);
    wr(AddrSteps, 16'd5);
    xfer(1'b1, AddrState, 16'h1357, q, stalls);
    chk("stall_cycles", stalls, 5);
    chk("stalled_state", lstate, 16'h1357);
    rd_chk("stalled_ctrl", AddrCtrl, 16'h000A);

    // STEPS reload while the counter is at 1: no DONE, burst continues
    setup(1'b0, 16'hB400, 16'h00A5);
    wr(AddrSteps, 16'd1);
    wr(AddrSteps, 16'd4);
    rd_chk("reload_ctrl", AddrCtrl, 16'h0004);
    wait_idle();
    model_run(1'b0, 16'hB400, 16'h00A5, 5, est, eb);
    rd_chk("reload_state", AddrState, est);
    rd_chk("reload_done", AddrCtrl, 16'h0008);

    // DONE clear in the expiry cycle loses to the set; a plain clear works
    setup(1'b1, 16'h8016, 16'h0F0F);
    wr(AddrSteps, 16'd1);
    wr(AddrCtrl, 16'h000A);
    rd_chk("done_set_wins", AddrCtrl, 16'h000A);
    model_run(1'b1, 16'h8016, 16'h0F0F, 1, est, eb);
    chk("done_race_state", lstate, est);
    wr(AddrCtrl, 16'h000A);
    rd_chk("done_w1c", AddrCtrl, 16'h0002);

    // Back-to-back reads of all registers
    setup(1'b1, 16'h1234, 16'hBEEF);
    exp4 = '{16'h0002, 16'h1234, 16'hBEEF, 16'h0000};
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = i[1:0];
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", i), ack, 1);
      chk($sformatf("b2b_data%0d", i), rdata, exp4[i]);
    end
    stb = 1'b0;
    @(posedge clk); #1;
    chk("b2b_no_extra_ack", ack, 0);

    // CYC drop suppresses the pending ack
    stb = 1'b1; addr = AddrState;
    @(posedge clk); #1;
    chk("drop_first_ack", ack, 1);
    addr = AddrTaps;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    #1;
    chk("drop_ack_suppressed", ack, 0);
    @(posedge clk); #1;
    chk("drop_no_later_ack", ack, 0);
    cyc = 1'b1;

    // Reset in the middle of a long burst and an in-flight read
    wr(AddrSteps, 16'd100);
    repeat (3) @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = AddrCtrl;
    @(posedge clk); #1;
    chk("pre_rst_ack", ack, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_data", rdata, 0);
    chk("mid_rst_state", lstate, 16'h0001);
    chk("mid_rst_bit", lbit, 0);
    chk("mid_rst_stall", stall, 0);
    stb = 1'b0;
    @(posedge clk); #1;
    chk("rst_edge_state", lstate, 16'h0001);
    chk("rst_edge_ack", ack, 0);
    rst = 1'b0;
    rd_chk("post_rst_ctrl", AddrCtrl, 16'h0000);
    rd_chk("post_rst_steps", AddrSteps, 16'h0000);
    rd_chk("post_rst_taps", AddrTaps, 16'hB400);

    // 8-bit build, Galois free-run: period 15 from seed 1
    cyc8 = 1'b1; stb8 = 1'b1; we8 = 1'b1; addr8 = AddrCtrl; wdata8 = 8'h03;
    @(posedge clk); #1;
    chk("w8_ack", ack8, 1);
    stb8 = 1'b0; we8 = 1'b0;
    first = 0;
    prev8 = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k <= 15) begin
        chk($sformatf("w8_seq%0d", k), lstate8, seq8[k-1]);
        chk($sformatf("w8_bit%0d", k), lbit8, prev8[0]);
        prev8 = seq8[k-1];
      end
      if (lstate8 == 8'h01 && first == 0) first = k;
    end
    chk("w8_period", first, 15);
    stb8 = 1'b1; we8 = 1'b1; wdata8 = 8'h00;
    @(posedge clk); #1;
    stb8 = 1'b0; we8 = 1'b0;
    q[7:0] = lstate8;
    repeat (3) @(posedge clk);
    #1;
    chk("w8_stopped", lstate8, q[7:0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_lfsr_gen.md
WB_LFSR_GEN -- requirements
Module: wb_lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, LFSR state, taps and Wishbone data width; legal range 8..32.
REQ-002 SHALL have parameter RESET_TAPS, default 16'hB400 (zero-extended to WIDTH), which is the taps register reset value.
REQ-003 SHALL have parameter RESET_SEED, default 1, which is the state register reset value; 0 is coerced to 1.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_reset  in  1  asynchronous active-high reset.
REQ-007 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone pipelined cycle, strobe and write-enable.
REQ-008 i_wb_addr  in  2  register select: 0 CTRL, 1 TAPS, 2 STATE, 3 STEPS.
REQ-009 i_wb_data  in  WIDTH  write data.
REQ-010 o_wb_stall, o_wb_ack  out  1 each  Wishbone stall and acknowledge.
REQ-011 o_wb_data  out  WIDTH  read data, valid only while o_wb_ack=1.
REQ-012 o_lfsr_bit  out  1  serial output bit of the most recent step.
REQ-013 o_lfsr_state  out  WIDTH  current LFSR state.

Function
REQ-014 CTRL SHALL use bit0 RUN (RW, free-run), bit1 MODE (RW, 0 Fibonacci, 1 Galois), bit2 BUSY (RO, STEPS!=0) and bit3 DONE (sticky, write-1-to-clear); all other bits read 0.
REQ-015 Fibonacci step SHALL be fb=^(state&taps), state<={state[W-2:0],fb}, o_lfsr_bit<=state[W-1].
REQ-016 Galois step SHALL be o_lfsr_bit<=state[0], state<=(state>>1)^(state[0]?taps:0).
REQ-017 One step SHALL occur in each cycle where RUN=1 or STEPS!=0; no step otherwise, and state and bit hold.
REQ-018 A STEPS write of N SHALL load N; the counter decrements once per step, and the 1->0 transition sets DONE.
REQ-019 A STEPS write while BUSY SHALL reload the counter with the new value and SHALL NOT set DONE.
REQ-020 A STATE write SHALL load i_wb_data (0 coerced to 1) and take priority over a step in the same cycle.
REQ-021 STATE and TAPS writes while BUSY=1 SHALL hold o_wb_stall=1 until BUSY=0; all other accesses SHALL never stall.
REQ-022 An accepted request (cyc&stb&!stall) SHALL produce o_wb_ack=1 in exactly the next cycle, for one cycle, with one ack per request; back-to-back requests SHALL be acked on consecutive cycles.
REQ-023 Read data SHALL reflect register values sampled at acceptance.
REQ-024 If i_wb_cyc drops, any pending ack SHALL be suppressed.
REQ-025 Writing DONE=1 in the same cycle the counter reaches 0 SHALL leave DONE=1 (the set wins).
REQ-026 A MODE or TAPS change SHALL affect the next step only; the current state is retained.

Reset
REQ-027 On i_reset, the block SHALL set state=RESET_SEED, taps=RESET_TAPS, CTRL=0, STEPS=0, o_lfsr_bit=0, o_wb_ack=0 and o_wb_data=0; o_wb_stall=0.
REQ-028 Reset mid-burst or mid-transaction SHALL abort it with no ack and no DONE.

Structure
REQ-029 Package wb_lfsr_pkg SHALL hold register address constants, CTRL bit indices and the mode enum (FIBONACCI, GALOIS).
REQ-030 Sub-module lfsr_step (combinational: state, taps, mode -> next state, out bit) SHALL be instantiated once.

Verification
REQ-031 Galois, seed 1, taps 0xB400, STEPS=2 -> states 0xB400 then 0x5A00, bits 1 then 0, DONE=1, BUSY=0.
REQ-032 Fibonacci, seed 1, taps 0xB400, STEPS=11 -> state 0x0400 after 10 steps and 0x0801 after 11.
REQ-033 WIDTH=8 build with taps 0x0C and seed 1, Galois, RUN=1 -> state returns to 0x01 first after exactly 15 steps (sequence C,6,3,D,A,5,E,7,F,B,9,8,4,2,1).
REQ-034 STATE write 0x0000 -> readback 0x0001; STATE write during STEPS=5 -> stall held 5 cycles, then ack.
REQ-035 Back-to-back reads of all 4 registers -> 4 acks on consecutive cycles with correct data; drop cyc mid-stream -> no further acks.
REQ-036 Assert i_reset during a STEPS=100 burst -> all outputs at reset values next edge; DONE stays 0.
